// File: rtl/soc_system_pll_rst_ctrl.sv
// ---------------------------------------------------------------------------
// soc_system_pll_rst_ctrl
//
// Reset/lock sequencer for the fabric PLL (50 MHz ref -> 150 MHz out).
// Each attempt pulses the PLL reset and then waits for lock, with a timeout
// and a bounded number of retries. Lock must then stay high for a number of
// cycles before the downstream clock-domain reset is released. Loss of lock
// or a software re-lock request restarts the sequence. Everything runs in
// the refclk domain.
//
// Optional build macro: SOC_PLL_LOL_FILTER_EN
//   defined   : in RUN, loss of lock needs LOL_FILTER_CYCLES consecutive
//               low cycles of the synchronised lock.
//   undefined : a single low cycle in RUN is loss of lock; no filter counter.
//
// Ports
//   refclk_i      reference clock, the only clock
//   rst_i         synchronous active-high reset
//   pll_locked_i  PLL lock, asynchronous (2-flop synchronised here)
//   relock_req_i  single-cycle request to restart the sequence
//   pll_rst_o     reset to the PLL
//   domain_rst_o  active-high reset for logic on the PLL output clock
//   ready_o       PLL locked and stable, domain released
//   fail_o        retries exhausted
//   retry_cnt_o   retries used in the current sequence (saturating)
//   lol_cnt_o     saturating count of loss-of-lock events since reset
// ---------------------------------------------------------------------------
module soc_system_pll_rst_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int LOL_FILTER_CYCLES   = 4
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       domain_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o,
  output logic [7:0] lol_cnt_o
);

  // One shared cycle counter sized for the longest state duration.
  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                             CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic             sync1_q, locked_s_q;
  logic             pll_rst_d, domain_rst_d, ready_d, fail_d;
  logic             lol_detect;

  // -------------------------------------------------------------------------
  // Loss-of-lock detection (only consulted while in RUN)
  // -------------------------------------------------------------------------
`ifdef SOC_PLL_LOL_FILTER_EN
  localparam int FILT_W = (LOL_FILTER_CYCLES > 1) ? $clog2(LOL_FILTER_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOL_FILTER_CYCLES - 1);

  logic [FILT_W-1:0] filt_q, filt_d;

  // Counts consecutive low cycles in RUN; any high cycle or leaving RUN
  // clears it, so ready stays up while a short glitch is being filtered.
  always_comb begin
    filt_d     = '0;
    lol_detect = 1'b0;
    if (state_q == ST_RUN && !locked_s_q) begin
      if (filt_q == FILT_LAST) lol_detect = 1'b1;
      else                     filt_d     = filt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) filt_q <= '0;
    else       filt_q <= filt_d;
  end
`else
  assign lol_detect = !locked_s_q;

  // The filter length has no meaning in this build.
  logic lol_filter_unused;
  assign lol_filter_unused = (LOL_FILTER_CYCLES > 0);
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lol_d   = lol_q;

    unique case (state_q)
      ST_RESET_PLL: if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABLE: begin
        // A low cycle restarts the wait without consuming a retry.
        if (!locked_s_q)                state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (lol_detect) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
          if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET_PLL;
    endcase

    // Software request outranks loss of lock and timeouts, and does not
    // count as a loss-of-lock event.
    if (relock_req_i) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
      lol_d   = lol_q;
    end

    // Counter restarts on any state change, and on every relock so a held
    // request keeps the reset pulse from completing. RUN and FAIL never use it.
    if (state_d != state_q || relock_req_i ||
        state_q == ST_RUN || state_q == ST_FAIL) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they move with the state.
    pll_rst_d    = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    domain_rst_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  // -------------------------------------------------------------------------
  // State, counters, synchroniser and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would chain the two sync flops together.
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      lol_q        <= '0;
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      pll_rst_o    <= 1'b1;
      domain_rst_o <= 1'b1;
      ready_o      <= 1'b0;
      fail_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lol_q        <= lol_d;
      sync1_q      <= pll_locked_i;
      locked_s_q   <= sync1_q;
      pll_rst_o    <= pll_rst_d;
      domain_rst_o <= domain_rst_d;
      ready_o      <= ready_d;
      fail_o       <= fail_d;
    end
  end

  assign retry_cnt_o = retry_q;
  assign lol_cnt_o   = lol_q;

endmodule

// File: doc/soc_system_pll_rst_ctrl.md
Name: soc_system_pll_rst_ctrl

Overview:
- Reset/lock sequencer for the fabric PLL (50 MHz ref, 150 MHz out).
- Pulses the PLL reset and waits for lock with timeout and bounded retries, then requires lock to be stable before releasing the downstream clock-domain reset.
- Re-runs the sequence on loss of lock or on a software re-lock request.
- Runs entirely in the refclk domain.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles the PLL reset is held per attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles in WAIT_LOCK before the attempt is declared failed.
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required before release.
- MAX_RETRIES, 3: retries allowed after the first attempt before entering FAIL.
- LOL_FILTER_CYCLES, 4: consecutive lock-low cycles that count as loss of lock (only with the optional feature).

Ports:
- refclk, input, 1: reference clock; sole clock.
- rst, input, 1: synchronous active-high reset.
- pll_locked, input, 1: PLL locked output, asynchronous; 2-flop synchronised internally.
- relock_req, input, 1: single-cycle request to restart the sequence.
- pll_rst, output, 1: reset to the PLL.
- domain_rst, output, 1: active-high reset for logic on the PLL output clock.
- ready, output, 1: PLL locked and stable; domain released.
- fail, output, 1: retries exhausted.
- retry_cnt, output, 2: retries used in the current sequence; saturates at MAX_RETRIES.
- lol_cnt, output, 8: saturating count of loss-of-lock events since rst.

Behaviour:
- Reset: rst=1 at an edge forces the following:
  - state=RESET_PLL; pll_rst=1, domain_rst=1, ready=0, fail=0.
  - retry_cnt=0, lol_cnt=0; cycle counter=0; sync flops=0.
  - This holds mid-operation, from any state.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- locked_s is pll_locked after 2 flops (2-cycle latency).
- One shared cycle counter, width clog2 of the largest parameter, cleared on every state change.
- RESET_PLL:
  - pll_rst=1, domain_rst=1, ready=0.
  - After exactly RST_PULSE_CYCLES cycles in the state, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, domain_rst=1.
  - locked_s=1 → STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1:
    - retry_cnt==MAX_RETRIES → FAIL;
    - else retry_cnt+1 and go to RESET_PLL.
- STABLE:
  - pll_rst=0, domain_rst=1.
  - locked_s=0 → WAIT_LOCK (counter cleared, no retry consumed).
  - Counter reaching LOCK_STABLE_CYCLES-1 with locked_s=1 → RUN.
- RUN:
  - pll_rst=0, domain_rst=0, ready=1.
  - Loss of lock (locked_s=0 for 1 cycle, or per the filter) → RESET_PLL, with lol_cnt+1 (saturating at 255) and retry_cnt=0.
- FAIL:
  - pll_rst=1, domain_rst=1, fail=1, ready=0.
  - Exited only by rst or relock_req.
- relock_req:
  - In any state, → RESET_PLL with retry_cnt=0; fail clears on the same edge.
  - lol_cnt is not incremented.
- Priority: rst > relock_req > loss of lock / timeout > normal progress.
- relock_req held high keeps restarting RESET_PLL; this is legal, and the pulse completes only after release.
- Parameters of 1 are legal: the state lasts exactly 1 cycle.

Optional Feature:
- SOC_PLL_LOL_FILTER_EN defined:
  - In RUN, loss of lock requires locked_s=0 for LOL_FILTER_CYCLES consecutive cycles.
  - Any high cycle resets the filter count; ready stays 1 during filtering.
- Not defined:
  - A single low cycle of locked_s in RUN triggers loss of lock.
  - LOL_FILTER_CYCLES is ignored and no filter counter is built.

Test Plan (bench params RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2):
- Nominal lock: pll_locked rises 10 cycles after rst release → pll_rst high exactly 4 cycles; ready=1 and domain_rst=0 exactly 2+8 cycles after the rise; fail=0, retry_cnt=0.
- Never locks: pll_locked=0 → pll_rst pulses 3 times (4 cycles each, 32-cycle gaps); retry_cnt goes 1, 2; then fail=1 and pll_rst=1 held, with ready=0 throughout.
- Unstable lock: lock high 5 cycles, low 1, then high → no release until 8 consecutive synced-high cycles; retry_cnt stays 0.
- Loss of lock in RUN: drop pll_locked for 1 cycle → without the macro, ready=0 and pll_rst=1 two cycles later and lol_cnt=1; with SOC_PLL_LOL_FILTER_EN, a 1-cycle drop is ignored, and a 4-cycle drop sets lol_cnt=1.
- Recovery from FAIL: relock_req pulse → fail=0, retry_cnt=0, pll_rst pulse of 4; then lock → ready=1.
- Reset mid-sequence: assert rst during STABLE → next edge pll_rst=1, domain_rst=1, ready=0, all counters 0.
